bus_cycle_engine: RTL and testbench

- Parametrised bus interface engine that turns a single CPU transfer request of 1..MAX_BYTES bytes into a sequence of multiplexed address/data bus cycles on a BUS_W-bit bus.
- Each beat runs T1..T4, with wait states (Tw) inserted while ready is low.
- Sits between the CPU core and the external multiplexed bus, producing ALE/RD/WR/DEN/DT-R/IO-M.
- Successor to the fixed two-byte 8-bit bus control FSM: generalised width and beat count, ready-driven wait states, sign extension, optional bus timeout.

---
 rtl/bus_cycle_engine.sv | 239 +++++++++++++++++++++++
 tb/tb_bus_cycle_engine.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_cycle_engine.sv
// Multiplexed address/data bus cycle engine: one CPU request becomes
// 1..MAX_BYTES beats of T1..T4 (with Tw wait states) on a BUS_W-bit bus.
//
// Ports:
//   clk, rst (async, active-low)
//   CPU side : req, we, m_io, nbeats, sext, addr, wdata -> rdata, busy, done, err
//   Bus side : ready, ad_i -> a, ad_o, ad_oe, ale, rd_n, wr_n, den_n, dtr, iom
//
// Optional build macro BUS_TIMEOUT_EN: aborts a beat after TIMEOUT wait
// states with done+err; without it Tw waits forever and err is tied low.
module bus_cycle_engine #(
   parameter int ADDR_W    = 20,
   parameter int BUS_W     = 8,
   parameter int MAX_BYTES = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req,
   input  logic                           we,
   input  logic                           m_io,
   input  logic [$clog2(MAX_BYTES+1)-1:0] nbeats,
   input  logic                           sext,
   input  logic [ADDR_W-1:0]              addr,
   input  logic [BUS_W*MAX_BYTES-1:0]     wdata,
   output logic [BUS_W*MAX_BYTES-1:0]     rdata,
   output logic                           busy,
   output logic                           done,
   output logic                           err,
   input  logic                           ready,
   output logic [ADDR_W-1:0]              a,
   output logic [BUS_W-1:0]               ad_o,
   output logic                           ad_oe,
   input  logic [BUS_W-1:0]               ad_i,
   output logic                           ale,
   output logic                           rd_n,
   output logic                           wr_n,
   output logic                           den_n,
   output logic                           dtr,
   output logic                           iom
);

   localparam int DW   = BUS_W * MAX_BYTES;
   localparam int NB_W = $clog2(MAX_BYTES + 1);

   typedef enum logic [2:0] {
      IDLE, T1, T2, T3, TW, T4
   } state_t;

   state_t            state;
   logic [NB_W-1:0]   beat;
   logic [NB_W-1:0]   last;
   logic [ADDR_W-1:0] base;
   logic [DW-1:0]     wbuf;
   logic [DW-1:0]     rbuf;
   logic              we_r;
   logic              sext_r;
   logic [ADDR_W-1:0] a_inc;

`ifdef BUS_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0] wcnt;
   logic            err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // address of the following beat, wraps modulo 2^ADDR_W
   assign a_inc = base + ADDR_W'(beat) + ADDR_W'(1);

   function automatic logic [BUS_W-1:0] lane(
      input logic [DW-1:0]   v,
      input logic [NB_W-1:0] k
   );
      return v[int'(k)*BUS_W +: BUS_W];
   endfunction

   function automatic logic [DW-1:0] put_lane(
      input logic [DW-1:0]    v,
      input logic [NB_W-1:0]  k,
      input logic [BUS_W-1:0] d
   );
      logic [DW-1:0] r;
      r = v;
      r[int'(k)*BUS_W +: BUS_W] = d;
      return r;
   endfunction

   // lanes above the last beat become sign copies or zero
   function automatic logic [DW-1:0] extend(
      input logic [DW-1:0]   v,
      input logic [NB_W-1:0] lk,
      input logic            s
   );
      logic [DW-1:0] r;
      logic          msb;
      r   = v;
      msb = s & v[int'(lk)*BUS_W + BUS_W - 1];
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (i > int'(lk)) r[i*BUS_W +: BUS_W] = {BUS_W{msb}};
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         beat   <= '0;
         last   <= '0;
         base   <= '0;
         wbuf   <= '0;
         rbuf   <= '0;
         we_r   <= 1'b0;
         sext_r <= 1'b0;
         rdata  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         ale    <= 1'b0;
         ad_oe  <= 1'b0;
         rd_n   <= 1'b1;
         wr_n   <= 1'b1;
         den_n  <= 1'b1;
         dtr    <= 1'b1;
         iom    <= 1'b1;
         a      <= '0;
         ad_o   <= '0;
`ifdef BUS_TIMEOUT_EN
         wcnt   <= '0;
         err_q  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  base   <= addr;
                  wbuf   <= wdata;
                  we_r   <= we;
                  sext_r <= sext;
                  rbuf   <= rdata;
                  if (nbeats == '0 || int'(nbeats) > MAX_BYTES)
                     last <= NB_W'(MAX_BYTES - 1);
                  else
                     last <= nbeats - 1'b1;
                  beat  <= '0;
                  state <= T1;
                  busy  <= 1'b1;
                  ale   <= 1'b1;
                  ad_oe <= 1'b1;
                  a     <= addr;
                  ad_o  <= addr[BUS_W-1:0];
                  iom   <= ~m_io;
                  dtr   <= we;
               end
            end
            T1: begin
               state <= T2;
               ale   <= 1'b0;
               den_n <= 1'b0;
               if (we_r) begin
                  wr_n  <= 1'b0;
                  ad_oe <= 1'b1;
                  ad_o  <= lane(wbuf, beat);
               end else begin
                  rd_n  <= 1'b0;
                  ad_oe <= 1'b0;
                  ad_o  <= '0;
               end
            end
            T2: begin
               state <= T3;
`ifdef BUS_TIMEOUT_EN
               wcnt  <= '0;
`endif
            end
            T3, TW: begin
               if (ready) begin
                  state <= T4;
                  rd_n  <= 1'b1;
                  wr_n  <= 1'b1;
                  den_n <= 1'b1;
                  ad_oe <= 1'b0;
                  ad_o  <= '0;
                  if (!we_r) rbuf <= put_lane(rbuf, beat, ad_i);
                  if (beat == last) begin
                     done <= 1'b1;
                     if (!we_r)
                        rdata <= extend(put_lane(rbuf, beat, ad_i),
                                        last, sext_r);
                  end
               end
`ifdef BUS_TIMEOUT_EN
               else if (state == TW && wcnt == TO_W'(TIMEOUT - 1)) begin
                  // abort: skip remaining beats, keep untouched lanes
                  state <= T4;
                  rd_n  <= 1'b1;
                  wr_n  <= 1'b1;
                  den_n <= 1'b1;
                  ad_oe <= 1'b0;
                  ad_o  <= '0;
                  beat  <= last;
                  done  <= 1'b1;
                  err_q <= 1'b1;
                  if (!we_r) rdata <= rbuf;
               end
`endif
               else begin
                  state <= TW;
`ifdef BUS_TIMEOUT_EN
                  if (state == TW) wcnt <= wcnt + 1'b1;
`endif
               end
            end
            T4: begin
               done  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
               err_q <= 1'b0;
`endif
               if (beat == last) begin
                  state <= IDLE;
                  beat  <= '0;
                  busy  <= 1'b0;
                  dtr   <= 1'b1;
                  iom   <= 1'b1;
               end else begin
                  state <= T1;
                  beat  <= beat + 1'b1;
                  ale   <= 1'b1;
                  ad_oe <= 1'b1;
                  a     <= a_inc;
                  ad_o  <= a_inc[BUS_W-1:0];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_cycle_engine.sv
// Directed bench for bus_cycle_engine: reads, writes, sign extension,
// wait states, clamped beat count, reset mid-transfer, optional timeout.
module tb_bus_cycle_engine;

   localparam int ADDR_W    = 20;
   localparam int BUS_W     = 8;
   localparam int MAX_BYTES = 2;
   localparam int TIMEOUT   = 4;

   logic              clk;
   logic              rst;
   logic              req;
   logic              we;
   logic              m_io;
   logic [1:0]        nbeats;
   logic              sext;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       wdata;
   logic [15:0]       rdata;
   logic              busy;
   logic              done;
   logic              err;
   logic              ready;
   logic [ADDR_W-1:0] a;
   logic [7:0]        ad_o;
   logic              ad_oe;
   logic [7:0]        ad_i;
   logic              ale;
   logic              rd_n;
   logic              wr_n;
   logic              den_n;
   logic              dtr;
   logic              iom;

   bus_cycle_engine #(
      .ADDR_W(ADDR_W),
      .BUS_W(BUS_W),
      .MAX_BYTES(MAX_BYTES),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .m_io(m_io),
      .nbeats(nbeats), .sext(sext), .addr(addr), .wdata(wdata),
      .rdata(rdata), .busy(busy), .done(done), .err(err),
      .ready(ready), .a(a), .ad_o(ad_o), .ad_oe(ad_oe), .ad_i(ad_i),
      .ale(ale), .rd_n(rd_n), .wr_n(wr_n), .den_n(den_n),
      .dtr(dtr), .iom(iom)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vecs = 0;
   int errs = 0;

   int                done_c;
   int                ale_cnt;
   int                rd_low;
   int                wr_low;
   int                wr_ok;
   logic              err_done;
   logic              iom_t1;
   logic              dtr_t1;
   logic              busy_after;
   logic              done_after;
   logic [ADDR_W-1:0] a_obs [4];
   logic [7:0]        ado_obs [4];

   // runs one transfer; ready is held low for nwait cycles starting in T3
   task automatic xfer(
      input logic        t_we,
      input logic        t_mio,
      input logic [1:0]  t_nb,
      input logic        t_sx,
      input logic [19:0] t_ad,
      input logic [15:0] t_wd,
      input logic [7:0]  l0,
      input logic [7:0]  l1,
      input int          nwait,
      input int          reqhold
   );
      logic [7:0] rl [2];
      logic [7:0] wl [2];
      int k;
      rl[0] = l0;
      rl[1] = l1;
      wl[0] = t_wd[7:0];
      wl[1] = t_wd[15:8];
      done_c = -1; ale_cnt = 0; rd_low = 0; wr_low = 0; wr_ok = 0;
      err_done = 1'b0; iom_t1 = 1'b0; dtr_t1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a_obs[i] = '0;
         ado_obs[i] = '0;
      end
      @(negedge clk);
      we = t_we; m_io = t_mio; nbeats = t_nb; sext = t_sx;
      addr = t_ad; wdata = t_wd; ready = 1'b1; ad_i = l0; req = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 100; c++) begin
         req = (c < reqhold);
         if (ale) begin
            if (ale_cnt < 4) begin
               a_obs[ale_cnt] = a;
               ado_obs[ale_cnt] = ad_o;
            end
            if (ale_cnt == 0) begin
               iom_t1 = iom;
               dtr_t1 = dtr;
            end
            ale_cnt++;
         end
         k = (ale_cnt > 1) ? 1 : 0;
         ad_i = rl[k];
         if (!rd_n) rd_low++;
         if (!wr_n) begin
            wr_low++;
            if (ad_oe && ad_o == wl[k]) wr_ok++;
         end
         ready = !(c >= 2 && c < 2 + nwait);
         if (done) begin
            done_c = c;
            err_done = err;
            break;
         end
         @(posedge clk); #1;
      end
      req = 1'b0;
      ready = 1'b1;
      @(posedge clk); #1;
      busy_after = busy;
      done_after = done;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      vecs++;
      if ({busy, done, err, ale, ad_oe, rd_n, wr_n, den_n, dtr, iom}
          !== 10'b00000_11111) begin
         errs++;
         $display("FAIL reset_strobes got %b want %b",
            {busy, done, err, ale, ad_oe, rd_n, wr_n, den_n, dtr, iom},
            10'b00000_11111);
      end
      vecs++;
      if (a !== '0 || ad_o !== '0 || rdata !== '0) begin
         errs++;
         $display("FAIL reset_data got a=%h ad_o=%h rdata=%h want 0",
            a, ad_o, rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (busy !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle got busy=%b want 0", busy);
      end
   endtask

   task automatic test_read2;
      xfer(1'b0, 1'b1, 2'd2, 1'b0, 20'h0FFFF, 16'h0, 8'h34, 8'h12, 0, 2);
      vecs++;
      if (done_c !== 7) begin
         errs++;
         $display("FAIL rd2_latency got %0d want 7", done_c);
      end
      vecs++;
      if (ale_cnt !== 2) begin
         errs++;
         $display("FAIL rd2_ale_count got %0d want 2", ale_cnt);
      end
      vecs++;
      if (a_obs[0] !== 20'h0FFFF || a_obs[1] !== 20'h10000) begin
         errs++;
         $display("FAIL rd2_addr got %h,%h want 0ffff,10000",
            a_obs[0], a_obs[1]);
      end
      vecs++;
      if (ado_obs[0] !== 8'hFF || ado_obs[1] !== 8'h00) begin
         errs++;
         $display("FAIL rd2_ad_t1 got %h,%h want ff,00",
            ado_obs[0], ado_obs[1]);
      end
      vecs++;
      if (rdata !== 16'h1234) begin
         errs++;
         $display("FAIL rd2_rdata got %h want 1234", rdata);
      end
      vecs++;
      if ({iom_t1, dtr_t1, err_done} !== 3'b000 || rd_low !== 4) begin
         errs++;
         $display("FAIL rd2_strobes got iom=%b dtr=%b err=%b rdlow=%0d want 0 0 0 4",
            iom_t1, dtr_t1, err_done, rd_low);
      end
      vecs++;
      if ({busy_after, done_after} !== 2'b00) begin
         errs++;
         $display("FAIL rd2_after got busy=%b done=%b want 0 0",
            busy_after, done_after);
      end
   endtask

   task automatic test_write;
      xfer(1'b1, 1'b0, 2'd1, 1'b0, 20'h00123, 16'h00AB, 8'h0, 8'h0, 0, 0);
      vecs++;
      if (done_c !== 3) begin
         errs++;
         $display("FAIL wr_latency got %0d want 3", done_c);
      end
      vecs++;
      if ({iom_t1, dtr_t1} !== 2'b11) begin
         errs++;
         $display("FAIL wr_iom_dtr got %b%b want 11", iom_t1, dtr_t1);
      end
      vecs++;
      if (wr_low !== 2 || wr_ok !== 2) begin
         errs++;
         $display("FAIL wr_data got wrlow=%0d ok=%0d want 2 2",
            wr_low, wr_ok);
      end
      vecs++;
      if (a_obs[0] !== 20'h00123 || ado_obs[0] !== 8'h23) begin
         errs++;
         $display("FAIL wr_addr got %h/%h want 00123/23",
            a_obs[0], ado_obs[0]);
      end
      vecs++;
      if (rdata !== 16'h1234) begin
         errs++;
         $display("FAIL wr_rdata_hold got %h want 1234", rdata);
      end
   endtask

   task automatic test_sext;
      xfer(1'b0, 1'b1, 2'd1, 1'b1, 20'h00400, 16'h0, 8'h80, 8'h55, 0, 0);
      vecs++;
      if (rdata !== 16'hFF80) begin
         errs++;
         $display("FAIL sext1 got %h want ff80", rdata);
      end
      xfer(1'b0, 1'b1, 2'd1, 1'b0, 20'h00400, 16'h0, 8'h80, 8'h55, 0, 0);
      vecs++;
      if (rdata !== 16'h0080) begin
         errs++;
         $display("FAIL sext0 got %h want 0080", rdata);
      end
   endtask

   task automatic test_wait;
      xfer(1'b0, 1'b1, 2'd1, 1'b0, 20'h00010, 16'h0, 8'h5A, 8'h00, 3, 0);
      vecs++;
      if (done_c !== 6) begin
         errs++;
         $display("FAIL wait_latency got %0d want 6", done_c);
      end
      vecs++;
      if (rd_low !== 5) begin
         errs++;
         $display("FAIL wait_rd_low got %0d want 5", rd_low);
      end
      vecs++;
      if (rdata !== 16'h005A || err_done !== 1'b0) begin
         errs++;
         $display("FAIL wait_rdata got %h err=%b want 005a 0",
            rdata, err_done);
      end
   endtask

   task automatic test_back_to_back;
      xfer(1'b0, 1'b1, 2'd0, 1'b0, 20'h00200, 16'h0, 8'h11, 8'h22, 0, 0);
      vecs++;
      if (rdata !== 16'h2211 || done_c !== 7) begin
         errs++;
         $display("FAIL nb0_clamp got %h lat=%0d want 2211 7",
            rdata, done_c);
      end
      xfer(1'b0, 1'b1, 2'd3, 1'b1, 20'h00300, 16'h0, 8'h01, 8'hC3, 0, 0);
      vecs++;
      if (rdata !== 16'hC301 || ale_cnt !== 2) begin
         errs++;
         $display("FAIL nb3_clamp got %h beats=%0d want c301 2",
            rdata, ale_cnt);
      end
   endtask

   task automatic test_timeout;
`ifdef BUS_TIMEOUT_EN
      xfer(1'b0, 1'b1, 2'd2, 1'b0, 20'h00500, 16'h0, 8'hEE, 8'hDD, 1000, 0);
      vecs++;
      if (done_c !== 7 || err_done !== 1'b1) begin
         errs++;
         $display("FAIL timeout_done got lat=%0d err=%b want 7 1",
            done_c, err_done);
      end
      vecs++;
      if (ale_cnt !== 1 || rdata !== 16'hC301) begin
         errs++;
         $display("FAIL timeout_abort got beats=%0d rdata=%h want 1 c301",
            ale_cnt, rdata);
      end
      vecs++;
      if ({busy_after, done_after} !== 2'b00) begin
         errs++;
         $display("FAIL timeout_after got busy=%b done=%b want 0 0",
            busy_after, done_after);
      end
`endif
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      we = 1'b1; m_io = 1'b1; nbeats = 2'd2; sext = 1'b0;
      addr = 20'h00777; wdata = 16'hBEEF; req = 1'b1; ready = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (wr_n !== 1'b0 || busy !== 1'b1) begin
         errs++;
         $display("FAIL rstmid_t2 got wr_n=%b busy=%b want 0 1",
            wr_n, busy);
      end
      #2 rst = 1'b0;
      #1;
      vecs++;
      if ({busy, done, err, ale, ad_oe, rd_n, wr_n, den_n, dtr, iom}
          !== 10'b00000_11111) begin
         errs++;
         $display("FAIL rstmid_strobes got %b want %b",
            {busy, done, err, ale, ad_oe, rd_n, wr_n, den_n, dtr, iom},
            10'b00000_11111);
      end
      vecs++;
      if (a !== '0 || ad_o !== '0 || rdata !== '0) begin
         errs++;
         $display("FAIL rstmid_data got a=%h ad_o=%h rdata=%h want 0",
            a, ad_o, rdata);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         vecs++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_idle%0d got busy=%b done=%b want 0 0",
               i, busy, done);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; req = 1'b0; we = 1'b0; m_io = 1'b0; nbeats = '0;
      sext = 1'b0; addr = '0; wdata = '0; ready = 1'b1; ad_i = '0;
      test_reset();
      test_read2();
      test_write();
      test_sext();
      test_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
